// File: rtl/skullfet_cell_sequencer.sv
// Self-test sequencer for the SkullFET inverter/NAND pair: walks all four A/B vectors, samples synchronized outputs, counts mismatches.
// Optional first-failure capture ports are enabled with `define SKULLFET_SEQ_FAILLOG_EN.
module skullfet_cell_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [LOOPS_W-1:0] loops,
    input  logic               inv_y,
    input  logic               nand_y,
    output logic               drv_a,
    output logic               drv_b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_count,
    output logic [1:0]         vector
`ifdef SKULLFET_SEQ_FAILLOG_EN
    ,
    output logic               fail_valid,
    output logic [1:0]         fail_vec,
    output logic               fail_cell,
    output logic [LOOPS_W-1:0] fail_loop
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [LOOPS_W-1:0] loop_q, loop_d;
    logic [7:0]         settle_q, settle_d;
    logic [7:0]         err_q, err_d;
    logic               drv_a_q, drv_a_d;
    logic               drv_b_q, drv_b_d;
    logic               stop_seen_q, stop_seen_d;
    logic               inv_s1_q, inv_s2_q;
    logic               nand_s1_q, nand_s2_q;

    logic               inv_err, nand_err;
    logic [8:0]         err_sum;
    logic               start_accept;

    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign pass         = done && (err_q == 8'd0);
    assign err_count    = err_q;
    assign vector       = vec_q;
    assign drv_a        = drv_a_q;
    assign drv_b        = drv_b_q;
    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

    // An unknown synchronized value fails the equality test and falls into the mismatch branch.
    always_comb begin
        inv_err  = 1'b1;
        nand_err = 1'b1;
        if (inv_s2_q == ~drv_a_q) begin
            inv_err = 1'b0;
        end
        if (nand_s2_q == ~(drv_a_q & drv_b_q)) begin
            nand_err = 1'b0;
        end
        err_sum = {1'b0, err_q} + {8'd0, inv_err} + {8'd0, nand_err};
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        loop_d      = loop_q;
        settle_d    = settle_q;
        err_d       = err_q;
        drv_a_d     = drv_a_q;
        drv_b_d     = drv_b_q;
        stop_seen_d = stop_seen_q;
        if (busy && stop) begin
            stop_seen_d = 1'b1;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_d       = 2'd0;
                    loop_d      = '0;
                    err_d       = 8'd0;
                    stop_seen_d = 1'b0;
                end
            end
            DRIVE: begin
                drv_a_d  = vec_q[1];
                drv_b_d  = vec_q[0];
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            SAMPLE: begin
                err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = DRIVE;
                end else begin
                    loop_d = loop_q + 1'b1;
                    if (stop || stop_seen_q || ((loops != '0) && (loop_d == loops))) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = 2'd0;
                        state_d = DRIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            loop_q      <= '0;
            settle_q    <= 8'd0;
            err_q       <= 8'd0;
            drv_a_q     <= 1'b0;
            drv_b_q     <= 1'b0;
            stop_seen_q <= 1'b0;
            inv_s1_q    <= 1'b0;
            inv_s2_q    <= 1'b0;
            nand_s1_q   <= 1'b0;
            nand_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            loop_q      <= loop_d;
            settle_q    <= settle_d;
            err_q       <= err_d;
            drv_a_q     <= drv_a_d;
            drv_b_q     <= drv_b_d;
            stop_seen_q <= stop_seen_d;
            inv_s1_q    <= inv_y;
            inv_s2_q    <= inv_s1_q;
            nand_s1_q   <= nand_y;
            nand_s2_q   <= nand_s1_q;
        end
    end

`ifdef SKULLFET_SEQ_FAILLOG_EN
    logic               fail_valid_q;
    logic [1:0]         fail_vec_q;
    logic               fail_cell_q;
    logic [LOOPS_W-1:0] fail_loop_q;

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign fail_cell  = fail_cell_q;
    assign fail_loop  = fail_loop_q;

    // Only the first mismatch of a run is kept; NAND wins when both cells disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_cell_q  <= 1'b0;
            fail_loop_q  <= '0;
        end else if (start_accept) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_cell_q  <= 1'b0;
            fail_loop_q  <= '0;
        end else if ((state_q == SAMPLE) && (inv_err || nand_err) && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
            fail_cell_q  <= nand_err;
            fail_loop_q  <= loop_q;
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_skullfet_cell_sequencer.sv
// Directed bench for skullfet_cell_sequencer driving behavioural SkullFET cells with optional stuck-at faults.
module tb_skullfet_cell_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       stop;
    logic [7:0] loops;
    logic       invY, nandY;
    logic       drvA, drvB, busy, done, pass;
    logic [7:0] errCount;
    logic [1:0] vector;
    logic       invStuck0, nandStuck1;
    int         testsRun, testsFailed;
`ifdef SKULLFET_SEQ_FAILLOG_EN
    logic       failValid;
    logic [1:0] failVec;
    logic       failCell;
    logic [7:0] failLoop;
`endif

    always #5 clk = ~clk;

    assign invY  = invStuck0  ? 1'b0 : ~drvA;
    assign nandY = nandStuck1 ? 1'b1 : ~(drvA & drvB);

    skullfet_cell_sequencer #(.SETTLE_CYCLES(4), .LOOPS_W(8)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .start     (start),
        .stop      (stop),
        .loops     (loops),
        .inv_y     (invY),
        .nand_y    (nandY),
        .drv_a     (drvA),
        .drv_b     (drvB),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (errCount),
        .vector    (vector)
`ifdef SKULLFET_SEQ_FAILLOG_EN
        ,
        .fail_valid(failValid),
        .fail_vec  (failVec),
        .fail_cell (failCell),
        .fail_loop (failLoop)
`endif
    );

    // Pulses start for one cycle; returns at the falling edge right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] loopsVal);
        @(negedge clk);
        loops = loopsVal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        testsRun++;
        if ({drvA, drvB, busy, done, pass, errCount, vector} !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_values got=%h want=0", {drvA, drvB, busy, done, pass, errCount, vector});
        end
    endtask

    task automatic test_healthy;
        int k;
        logic [1:0] expVec;
        invStuck0 = 1'b0;
        nandStuck1 = 1'b0;
        applyStimulus(8'd1);
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL healthy_busy got=%b want=1", busy);
        end
        for (k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k % 6 == 1) begin
                expVec = 2'(k / 6);
                testsRun++;
                if ({drvA, drvB} !== expVec) begin
                    testsFailed++;
                    $display("[TB] FAIL healthy_drv_%0d got=%b want=%b", k / 6, {drvA, drvB}, expVec);
                end
            end
            if (k == 23) begin
                testsRun++;
                if (done !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL healthy_early_done got=%b want=0", done);
                end
            end
        end
        testsRun++;
        if ({done, pass, busy, errCount} !== {3'b110, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL healthy_result done/pass/busy/err got=%b%b%b/%0d want=110/0", done, pass, busy, errCount);
        end
    endtask

    task automatic test_inv_stuck;
        int cycles;
        invStuck0 = 1'b1;
        nandStuck1 = 1'b0;
        applyStimulus(8'd3);
        waitDone(200, cycles);
        testsRun++;
        if (cycles !== 72 || errCount !== 8'd6 || pass !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL inv_stuck cycles/err/pass got=%0d/%0d/%b want=72/6/0", cycles, errCount, pass);
        end
`ifdef SKULLFET_SEQ_FAILLOG_EN
        testsRun++;
        if ({failValid, failVec, failCell, failLoop} !== {1'b1, 2'd0, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL inv_faillog got=%b/%0d/%b/%0d want=1/0/0/0", failValid, failVec, failCell, failLoop);
        end
`endif
    endtask

    task automatic test_nand_stuck;
        int cycles;
        invStuck0 = 1'b0;
        nandStuck1 = 1'b1;
        applyStimulus(8'd200);
        waitDone(6000, cycles);
        testsRun++;
        if (cycles !== 4800 || errCount !== 8'd200 || pass !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL nand_stuck cycles/err/pass got=%0d/%0d/%b want=4800/200/0", cycles, errCount, pass);
        end
`ifdef SKULLFET_SEQ_FAILLOG_EN
        testsRun++;
        if ({failValid, failVec, failCell, failLoop} !== {1'b1, 2'd3, 1'b1, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL nand_faillog got=%b/%0d/%b/%0d want=1/3/1/0", failValid, failVec, failCell, failLoop);
        end
`endif
    endtask

    task automatic test_both_stuck;
        int cycles;
        invStuck0 = 1'b1;
        nandStuck1 = 1'b1;
        applyStimulus(8'd200);
        waitDone(6000, cycles);
        testsRun++;
        if (cycles !== 4800 || errCount !== 8'd255) begin
            testsFailed++;
            $display("[TB] FAIL both_stuck_saturate cycles/err got=%0d/%0d want=4800/255", cycles, errCount);
        end
    endtask

    task automatic test_stop;
        int cycles;
        invStuck0 = 1'b0;
        nandStuck1 = 1'b0;
        applyStimulus(8'd0);
        cycles = 0;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            start = (cycles == 50);
            stop  = (cycles == 106);
        end
        start = 1'b0;
        stop = 1'b0;
        testsRun++;
        if (cycles !== 120 || pass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stop_pass5 cycles/pass got=%0d/%b want=120/1", cycles, pass);
        end
    endtask

    task automatic test_reset_mid_run;
        int cycles;
        invStuck0 = 1'b1;
        nandStuck1 = 1'b0;
        applyStimulus(8'd1);
        repeat (15) @(negedge clk);
        testsRun++;
        if ({drvA, drvB, busy, errCount} !== {3'b101, 8'd2}) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset drv/busy/err got=%b%b/%b/%0d want=10/1/2", drvA, drvB, busy, errCount);
        end
        #2 rstN = 1'b0;
        #1;
        testsRun++;
        if ({drvA, drvB, busy, done, pass, errCount, vector} !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset got=%h want=0", {drvA, drvB, busy, done, pass, errCount, vector});
        end
        @(negedge clk);
        rstN = 1'b1;
        invStuck0 = 1'b0;
        applyStimulus(8'd1);
        testsRun++;
        if (vector !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL restart_vector got=%0d want=0", vector);
        end
        waitDone(200, cycles);
        testsRun++;
        if (cycles !== 24 || errCount !== 8'd0 || pass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart cycles/err/pass got=%0d/%0d/%b want=24/0/1", cycles, errCount, pass);
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rstN = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loops = 8'd0;
        invStuck0 = 1'b0;
        nandStuck1 = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rstN = 1'b1;
        test_healthy;
        test_inv_stuck;
        test_nand_stuck;
        test_both_stuck;
        test_stop;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
